// File: rtl/ppu_pkg.sv
// ----------------------------------------------------------------------------
// ppu_pkg
// Shared types for the PPU CPU-facing register window.
//   ppu_reg_e     : register index within the $2000-$2007 window
//   loopy_addr_t  : layout of the loopy t/v scroll address
//   dp_state_e    : $2007 data-port sequencer states
//   vaddr_step()  : v increment selected by PPUCTRL[2]
// ----------------------------------------------------------------------------
package ppu_pkg;

    typedef enum logic [2:0] {
        REG_PPUCTRL   = 3'd0,
        REG_PPUMASK   = 3'd1,
        REG_PPUSTATUS = 3'd2,
        REG_OAMADDR   = 3'd3,
        REG_OAMDATA   = 3'd4,
        REG_PPUSCROLL = 3'd5,
        REG_PPUADDR   = 3'd6,
        REG_PPUDATA   = 3'd7
    } ppu_reg_e;

    typedef struct packed {
        logic [2:0] fine_y;
        logic [1:0] nt;
        logic [4:0] coarse_y;
        logic [4:0] coarse_x;
    } loopy_addr_t;

    typedef enum logic [2:0] {
        DP_IDLE,
        DP_WR,
        DP_RD,
        DP_LATCH,
        DP_INC
    } dp_state_e;

    localparam logic [13:0] PAL_BASE_DEFAULT = 14'h3F00;
    localparam int unsigned VADDR_W_DEFAULT  = 14;

    function automatic logic [14:0] vaddr_step(input logic inc32);
        return inc32 ? 15'd32 : 15'd1;
    endfunction

endpackage

// File: rtl/ppu_data_port.sv
// ----------------------------------------------------------------------------
// ppu_data_port
// $2007 sequencer: owns the loopy v register, the buffered-read latch and
// the VRAM write strobe.
//   clk, reset_n      : clock, async active-low reset
//   i_start_wr/rd     : $2007 write/read strobe (ignored unless idle)
//   i_wdata           : $2007 write data
//   i_inc32           : PPUCTRL[2], selects +32 instead of +1
//   i_v_load/_val     : $2006 second-write load of v
//   i_vram_rdata      : VRAM read data (1-clk latency)
//   o_vram_addr/wdata/we : VRAM port
//   o_rd_valid/o_rd_data : read result, valid for one clk in LATCH
// ----------------------------------------------------------------------------
module ppu_data_port
    import ppu_pkg::*;
#(
    parameter logic [13:0] PAL_BASE = PAL_BASE_DEFAULT,
    parameter int unsigned VADDR_W  = VADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start_wr,
    input  logic               i_start_rd,
    input  logic [7:0]         i_wdata,
    input  logic               i_inc32,
    input  logic               i_v_load,
    input  logic [14:0]        i_v_load_val,
    input  logic [7:0]         i_vram_rdata,
    output logic [VADDR_W-1:0] o_vram_addr,
    output logic [7:0]         o_vram_wdata,
    output logic               o_vram_we,
    output logic               o_rd_valid,
    output logic [7:0]         o_rd_data
);

    dp_state_e   r_state;
    logic [14:0] r_v;
    logic [7:0]  r_buf;
    logic [14:0] w_v_base;
    logic        w_pal;

    // A $2006 load landing on the INC edge is incremented, so INC always
    // works from the most recent v.
    assign w_v_base    = i_v_load ? i_v_load_val : r_v;
    assign w_pal       = (r_v[13:0] >= PAL_BASE);
    assign o_vram_addr = r_v[VADDR_W-1:0];
    assign o_rd_valid  = (r_state == DP_LATCH);
    // Palette reads bypass the buffer; everything else returns the old buffer.
    assign o_rd_data   = w_pal ? i_vram_rdata : r_buf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= DP_IDLE;
            r_v          <= '0;
            r_buf        <= '0;
            o_vram_we    <= 1'b0;
            o_vram_wdata <= '0;
        end else begin
            o_vram_we <= 1'b0;
            case (r_state)
                DP_IDLE: begin
                    if (i_start_wr) begin
                        r_state      <= DP_WR;
                        o_vram_we    <= 1'b1;
                        o_vram_wdata <= i_wdata;
                    end else if (i_start_rd) begin
                        r_state <= DP_RD;
                    end
                end
                DP_WR:    r_state <= DP_INC;
                DP_RD:    r_state <= DP_LATCH;
                DP_LATCH: begin
                    r_buf   <= i_vram_rdata;
                    r_state <= DP_INC;
                end
                DP_INC:   r_state <= DP_IDLE;
                default:  r_state <= DP_IDLE;
            endcase

            if (r_state == DP_INC) begin
                r_v <= w_v_base + vaddr_step(i_inc32);
            end else if (i_v_load) begin
                r_v <= i_v_load_val;
            end
        end
    end

endmodule

// File: rtl/ppu_reg_file.sv
// ----------------------------------------------------------------------------
// ppu_reg_file
// PPU-side responder for the CPU $2000-$2007 register window.
//   clk, reset_n                 : clock, async active-low reset
//   cs, reg_addr, WE, data_in    : one-clk CPU access strobe, index, dir, data
//   data_out                     : CPU read data (held until next read)
//   vblank_set, frame_clr,
//   spr0_hit_set, spr_ovf_set    : timing pulses driving PPUSTATUS
//   vram_addr/data_in/data_out/WE: VRAM port (v, 1-clk read latency)
//   oam_addr/data_in/data_out/WE : OAM port (1-clk read latency)
//   ppu_ctrl, ppu_mask           : control registers to the renderer
//   loopy_t, fine_x              : scroll temp address and fine X
//   nmi_n                        : level NMI, ~(ctrl[7] & vblank)
// ----------------------------------------------------------------------------
module ppu_reg_file
    import ppu_pkg::*;
#(
    parameter logic [13:0] PAL_BASE = 14'h3F00,
    parameter int unsigned VADDR_W  = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cs,
    input  logic [2:0]         reg_addr,
    input  logic               WE,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic               vblank_set,
    input  logic               frame_clr,
    input  logic               spr0_hit_set,
    input  logic               spr_ovf_set,
    output logic [VADDR_W-1:0] vram_addr,
    input  logic [7:0]         vram_data_in,
    output logic [7:0]         vram_data_out,
    output logic               vram_WE,
    output logic [7:0]         oam_addr,
    input  logic [7:0]         oam_data_in,
    output logic [7:0]         oam_data_out,
    output logic               oam_WE,
    output logic [7:0]         ppu_ctrl,
    output logic [7:0]         ppu_mask,
    output logic [14:0]        loopy_t,
    output logic [2:0]         fine_x,
    output logic               nmi_n
);

    ppu_reg_e    w_reg;
    logic        w_wr;
    logic        w_rd;
    logic        w_v_load;
    logic [14:0] w_v_load_val;
    logic        w_dp_rd_valid;
    logic [7:0]  w_dp_rd_data;

    logic [7:0]  r_ctrl;
    logic [7:0]  r_mask;
    logic        r_vblank;
    logic        r_spr0;
    logic        r_ovf;
    logic        r_w;
    logic [2:0]  r_x;
    loopy_addr_t r_t;
    logic [7:0]  r_io_latch;
    logic [7:0]  r_oam_addr;
    logic        r_oam_we;
    logic [7:0]  r_oam_wdata;
    logic        r_oam_rd_pend;
    logic [7:0]  r_data_out;

    assign w_reg        = ppu_reg_e'(reg_addr);
    assign w_wr         = cs & WE;
    assign w_rd         = cs & ~WE;
    assign w_v_load     = w_wr & (w_reg == REG_PPUADDR) & r_w;
    assign w_v_load_val = {r_t[14:8], data_in};

    ppu_data_port #(
        .PAL_BASE (PAL_BASE),
        .VADDR_W  (VADDR_W)
    ) u_data_port (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start_wr   (w_wr & (w_reg == REG_PPUDATA)),
        .i_start_rd   (w_rd & (w_reg == REG_PPUDATA)),
        .i_wdata      (data_in),
        .i_inc32      (r_ctrl[2]),
        .i_v_load     (w_v_load),
        .i_v_load_val (w_v_load_val),
        .i_vram_rdata (vram_data_in),
        .o_vram_addr  (vram_addr),
        .o_vram_wdata (vram_data_out),
        .o_vram_we    (vram_WE),
        .o_rd_valid   (w_dp_rd_valid),
        .o_rd_data    (w_dp_rd_data)
    );

    assign data_out     = r_data_out;
    assign oam_addr     = r_oam_addr;
    assign oam_data_out = r_oam_wdata;
    assign oam_WE       = r_oam_we;
    assign ppu_ctrl     = r_ctrl;
    assign ppu_mask     = r_mask;
    assign loopy_t      = r_t;
    assign fine_x       = r_x;
    assign nmi_n        = ~(r_ctrl[7] & r_vblank);

    // STATUS flags: frame_clr beats any set pulse; a $2002 read on the same
    // edge as vblank_set keeps the flag clear (read suppression).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank <= 1'b0;
            r_spr0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (frame_clr) begin
                r_vblank <= 1'b0;
            end else if (w_rd && (w_reg == REG_PPUSTATUS)) begin
                r_vblank <= 1'b0;
            end else if (vblank_set) begin
                r_vblank <= 1'b1;
            end

            if (frame_clr) begin
                r_spr0 <= 1'b0;
            end else if (spr0_hit_set) begin
                r_spr0 <= 1'b1;
            end

            if (frame_clr) begin
                r_ovf <= 1'b0;
            end else if (spr_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Register writes, scroll latches and OAM port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl      <= '0;
            r_mask      <= '0;
            r_w         <= 1'b0;
            r_x         <= '0;
            r_t         <= '0;
            r_io_latch  <= '0;
            r_oam_addr  <= '0;
            r_oam_we    <= 1'b0;
            r_oam_wdata <= '0;
        end else begin
            r_oam_we <= 1'b0;
            // Post-increment once the OAM write strobe has been seen.
            if (r_oam_we) begin
                r_oam_addr <= r_oam_addr + 8'd1;
            end

            if (w_rd && (w_reg == REG_PPUSTATUS)) begin
                r_w <= 1'b0;
            end

            if (w_wr) begin
                r_io_latch <= data_in;
                case (w_reg)
                    REG_PPUCTRL: begin
                        r_ctrl <= data_in;
                        r_t.nt <= data_in[1:0];
                    end
                    REG_PPUMASK: r_mask <= data_in;
                    REG_OAMADDR: r_oam_addr <= data_in;
                    REG_OAMDATA: begin
                        r_oam_we    <= 1'b1;
                        r_oam_wdata <= data_in;
                    end
                    REG_PPUSCROLL: begin
                        if (!r_w) begin
                            r_t.coarse_x <= data_in[7:3];
                            r_x          <= data_in[2:0];
                            r_w          <= 1'b1;
                        end else begin
                            r_t.fine_y   <= data_in[2:0];
                            r_t.coarse_y <= data_in[7:3];
                            r_w          <= 1'b0;
                        end
                    end
                    REG_PPUADDR: begin
                        if (!r_w) begin
                            r_t[14:8] <= {1'b0, data_in[5:0]};
                            r_w       <= 1'b1;
                        end else begin
                            r_t[7:0] <= data_in;
                            r_w      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // CPU read data. $2004 waits one clk for OAM, $2007 comes from the
    // data port in LATCH; everything else is returned on the strobe edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out    <= '0;
            r_oam_rd_pend <= 1'b0;
        end else begin
            r_oam_rd_pend <= w_rd & (w_reg == REG_OAMDATA);
            if (w_dp_rd_valid) begin
                r_data_out <= w_dp_rd_data;
            end else if (r_oam_rd_pend) begin
                r_data_out <= oam_data_in;
            end else if (w_rd) begin
                case (w_reg)
                    REG_PPUSTATUS: r_data_out <= {r_vblank, r_spr0, r_ovf, r_io_latch[4:0]};
                    REG_OAMDATA:   ;
                    REG_PPUDATA:   ;
                    default:       r_data_out <= r_io_latch;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_file.sv
module tb_ppu_reg_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic [2:0]  reg_addr;
    logic        WE;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        vblank_set;
    logic        frame_clr;
    logic        spr0_hit_set;
    logic        spr_ovf_set;
    logic [13:0] vram_addr;
    logic [7:0]  vram_data_in;
    logic [7:0]  vram_data_out;
    logic        vram_WE;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data_in;
    logic [7:0]  oam_data_out;
    logic        oam_WE;
    logic [7:0]  ppu_ctrl;
    logic [7:0]  ppu_mask;
    logic [14:0] loopy_t;
    logic [2:0]  fine_x;
    logic        nmi_n;

    logic [7:0]  vmem [0:16383];
    logic [7:0]  omem [0:255];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_VBL  = 4'b1000;
    localparam logic [3:0] P_CLR  = 4'b0100;
    localparam logic [3:0] P_S0   = 4'b0010;
    localparam logic [3:0] P_OVF  = 4'b0001;

    always #5 clk = ~clk;

    ppu_reg_file #(
        .PAL_BASE (14'h3F00),
        .VADDR_W  (14)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cs            (cs),
        .reg_addr      (reg_addr),
        .WE            (WE),
        .data_in       (data_in),
        .data_out      (data_out),
        .vblank_set    (vblank_set),
        .frame_clr     (frame_clr),
        .spr0_hit_set  (spr0_hit_set),
        .spr_ovf_set   (spr_ovf_set),
        .vram_addr     (vram_addr),
        .vram_data_in  (vram_data_in),
        .vram_data_out (vram_data_out),
        .vram_WE       (vram_WE),
        .oam_addr      (oam_addr),
        .oam_data_in   (oam_data_in),
        .oam_data_out  (oam_data_out),
        .oam_WE        (oam_WE),
        .ppu_ctrl      (ppu_ctrl),
        .ppu_mask      (ppu_mask),
        .loopy_t       (loopy_t),
        .fine_x        (fine_x),
        .nmi_n         (nmi_n)
    );

    // Synchronous memories with one clock of read latency.
    always @(posedge clk) begin
        if (vram_WE) vmem[vram_addr] <= vram_data_out;
        vram_data_in <= vmem[vram_addr];
    end

    always @(posedge clk) begin
        if (oam_WE) omem[oam_addr] <= oam_data_out;
        oam_data_in <= omem[oam_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns 1 time unit after the edge that samples the strobe.
    task automatic strobe(input logic we, input logic [2:0] a, input logic [7:0] d, input logic [3:0] p);
        @(posedge clk); #1;
        cs = 1'b1; WE = we; reg_addr = a; data_in = d;
        {vblank_set, frame_clr, spr0_hit_set, spr_ovf_set} = p;
        @(posedge clk); #1;
        cs = 1'b0; WE = 1'b0;
        {vblank_set, frame_clr, spr0_hit_set, spr_ovf_set} = P_NONE;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        strobe(1'b1, a, d, P_NONE);
        settle();
    endtask

    task automatic rd(input logic [2:0] a);
        strobe(1'b0, a, 8'h00, P_NONE);
        settle();
    endtask

    task automatic pulse(input logic [3:0] p);
        @(posedge clk); #1;
        {vblank_set, frame_clr, spr0_hit_set, spr_ovf_set} = p;
        @(posedge clk); #1;
        {vblank_set, frame_clr, spr0_hit_set, spr_ovf_set} = P_NONE;
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; WE = 1'b0; reg_addr = '0; data_in = '0;
        {vblank_set, frame_clr, spr0_hit_set, spr_ovf_set} = P_NONE;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        settle();

        // Reset state
        check("rst_nmi_n",   32'(nmi_n),     32'h1);
        check("rst_dout",    32'(data_out),  32'h00);
        check("rst_vram_we", 32'(vram_WE),   32'h0);
        check("rst_v",       32'(vram_addr), 32'h0000);
        check("rst_t",       32'(loopy_t),   32'h0000);
        check("rst_x",       32'(fine_x),    32'h0);
        check("rst_oamaddr", 32'(oam_addr),  32'h00);

        // $2006 address load and $2007 write with +1 increment
        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        check("t_2006",      32'(loopy_t),   32'h2108);
        check("v_2006",      32'(vram_addr), 32'h2108);
        strobe(1'b1, 3'd7, 8'hAA, P_NONE);
        check("wr_we",       32'(vram_WE),       32'h1);
        check("wr_addr",     32'(vram_addr),     32'h2108);
        check("wr_data",     32'(vram_data_out), 32'hAA);
        settle();
        check("wr_we_off",   32'(vram_WE),   32'h0);
        check("v_inc1",      32'(vram_addr), 32'h2109);

        // +32 increment with ctrl[2]=1
        wr(3'd0, 8'h04);
        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        wr(3'd7, 8'hBB);
        check("v_inc32",     32'(vram_addr), 32'h2128);
        wr(3'd0, 8'h00);

        // Preload VRAM through the data port
        wr(3'd6, 8'h24); wr(3'd6, 8'h00);
        wr(3'd7, 8'h55); wr(3'd7, 8'h66);
        wr(3'd6, 8'h3F); wr(3'd6, 8'h00);
        wr(3'd7, 8'h0F);

        // Buffered reads
        wr(3'd6, 8'h24); wr(3'd6, 8'h00);
        rd(3'd7);
        check("rd1_stale",   32'(data_out),  32'h00);
        rd(3'd7);
        check("rd2_55",      32'(data_out),  32'h55);
        check("rd2_v",       32'(vram_addr), 32'h2402);

        // Palette read is direct and reloads the buffer
        wr(3'd6, 8'h3F); wr(3'd6, 8'h00);
        rd(3'd7);
        check("pal_direct",  32'(data_out),  32'h0F);
        check("pal_v",       32'(vram_addr), 32'h3F01);
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        rd(3'd7);
        check("pal_buf",     32'(data_out),  32'h0F);

        // $2007 strobe while busy (INC state) is ignored
        wr(3'd6, 8'h24); wr(3'd6, 8'h01);
        strobe(1'b0, 3'd7, 8'h00, P_NONE);
        @(posedge clk);
        strobe(1'b0, 3'd7, 8'h00, P_NONE);
        settle();
        check("busy_data",   32'(data_out),  32'hBB);
        check("busy_v",      32'(vram_addr), 32'h2402);
        rd(3'd7);
        check("busy_buf",    32'(data_out),  32'h66);

        // v crosses 3FFF -> 4000, vram_addr shows 14 bits
        wr(3'd6, 8'h3F); wr(3'd6, 8'hFF);
        check("v_3fff",      32'(vram_addr), 32'h3FFF);
        wr(3'd7, 8'h12);
        check("v_wrap14",    32'(vram_addr), 32'h0000);

        // $2005 scroll with a $2002 read resetting w
        wr(3'd0, 8'h00);
        wr(3'd5, 8'h13);
        check("x_first",     32'(fine_x),    32'h3);
        rd(3'd2);
        check("stat_latch",  32'(data_out),  32'h13);
        wr(3'd5, 8'h7D);
        wr(3'd5, 8'h5E);
        check("t_scroll",    32'(loopy_t),   32'h616F);
        check("x_scroll",    32'(fine_x),    32'h5);

        // NMI generation and $2002 vblank handling
        wr(3'd0, 8'h80);
        check("nmi_idle",    32'(nmi_n),     32'h1);
        pulse(P_VBL);
        check("nmi_low",     32'(nmi_n),     32'h0);
        rd(3'd2);
        check("stat_vbl",    32'(data_out),  32'h80);
        check("nmi_clr",     32'(nmi_n),     32'h1);
        strobe(1'b0, 3'd2, 8'h00, P_VBL);
        settle();
        check("stat_supp",   32'(data_out),  32'h00);
        check("nmi_supp",    32'(nmi_n),     32'h1);

        wr(3'd0, 8'h00);
        pulse(P_VBL);
        check("nmi_ctrl0",   32'(nmi_n),     32'h1);
        strobe(1'b1, 3'd0, 8'h80, P_NONE);
        check("nmi_ctrl_en", 32'(nmi_n),     32'h0);
        settle();
        pulse(P_CLR);
        check("nmi_frclr",   32'(nmi_n),     32'h1);

        // Sprite flags, and clear winning over set
        wr(3'd0, 8'h00);
        pulse(P_S0 | P_OVF);
        rd(3'd2);
        check("stat_s0ovf",  32'(data_out),  32'h60);
        rd(3'd2);
        check("stat_keep",   32'(data_out),  32'h60);
        pulse(P_CLR | P_S0);
        rd(3'd2);
        check("stat_clrwin", 32'(data_out),  32'h00);

        // OAM port
        wr(3'd3, 8'h10);
        strobe(1'b1, 3'd4, 8'h5A, P_NONE);
        check("oam_we",      32'(oam_WE),       32'h1);
        check("oam_wdata",   32'(oam_data_out), 32'h5A);
        check("oam_waddr",   32'(oam_addr),     32'h10);
        settle();
        check("oam_inc",     32'(oam_addr),  32'h11);
        check("oam_we_off",  32'(oam_WE),    32'h0);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hA5);
        check("oam_wrap",    32'(oam_addr),  32'h00);
        wr(3'd3, 8'h10);
        rd(3'd4);
        check("oam_rd",      32'(data_out),  32'h5A);
        check("oam_rd_addr", 32'(oam_addr),  32'h10);

        // Write-only registers read back the I/O latch
        wr(3'd1, 8'h3C);
        check("mask",        32'(ppu_mask),  32'h3C);
        rd(3'd1);
        check("rb_2001",     32'(data_out),  32'h3C);
        rd(3'd5);
        check("rb_2005",     32'(data_out),  32'h3C);
        rd(3'd2);
        check("stat_low5",   32'(data_out),  32'h1C);
        check("ctrl",        32'(ppu_ctrl),  32'h00);

        // Async reset in the middle of a $2007 write
        wr(3'd6, 8'h21); wr(3'd6, 8'h00);
        strobe(1'b1, 3'd7, 8'h77, P_NONE);
        check("ar_we_on",    32'(vram_WE),   32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_we_off",   32'(vram_WE),   32'h0);
        check("ar_v",        32'(vram_addr), 32'h0000);
        check("ar_mask",     32'(ppu_mask),  32'h00);
        check("ar_dout",     32'(data_out),  32'h00);
        @(posedge clk); #1 reset_n = 1'b1;
        settle();
        check("ar_idle_we",  32'(vram_WE),   32'h0);
        check("ar_idle_v",   32'(vram_addr), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
